// File: rtl/phy_tx_pkg.sv
// Shared constants for the phy_tx scheduler slice.
// Optional statistics counters are enabled with PHY_TX_SCHED_STATS_EN.
package phy_tx_pkg;

    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [7:0] COM_SYM = 8'hBC;

endpackage

// File: rtl/phy_tx_scheduler_if.sv
// Lane/serializer bundle between the four byte lanes and the scheduler.
// Counter outputs exist only with PHY_TX_SCHED_STATS_EN defined.
interface phy_tx_scheduler_if;
    import phy_tx_pkg::*;

    logic       enable;
    logic       tx_ready;
    logic [7:0] data_in0;
    logic [7:0] data_in1;
    logic [7:0] data_in2;
    logic [7:0] data_in3;
    logic       valid0;
    logic       valid1;
    logic       valid2;
    logic       valid3;
    logic       pop0;
    logic       pop1;
    logic       pop2;
    logic       pop3;
    logic [7:0] data_out;
    logic       valid_out;
    lane_t      lane_id;
    logic       active;
`ifdef PHY_TX_SCHED_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [15:0] grant_cnt2;
    logic [15:0] grant_cnt3;
    logic [15:0] idle_cnt;
`endif

    modport master (
        output enable, tx_ready,
        output data_in0, data_in1, data_in2, data_in3,
        output valid0, valid1, valid2, valid3,
        input  pop0, pop1, pop2, pop3,
        input  data_out, valid_out, lane_id, active
`ifdef PHY_TX_SCHED_STATS_EN
        , input grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3, idle_cnt
`endif
    );

    modport slave (
        input  enable, tx_ready,
        input  data_in0, data_in1, data_in2, data_in3,
        input  valid0, valid1, valid2, valid3,
        output pop0, pop1, pop2, pop3,
        output data_out, valid_out, lane_id, active
`ifdef PHY_TX_SCHED_STATS_EN
        , output grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3, idle_cnt
`endif
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: first requester at or after ptr wins.
// Purely combinational; en low suppresses every grant.
module rr_arbiter4
    import phy_tx_pkg::*;
(
    input  logic [3:0] req,
    input  lane_t      ptr,
    input  logic       en,
    output logic [3:0] grant,
    output lane_t      grant_idx
);

    logic  found;
    lane_t cand;

    // Walk lanes ptr, ptr+1, ... (mod 4) and take the first request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + lane_t'(i);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/phy_tx_scheduler.sv
// Round-robin byte scheduler with COM-symbol link sync and idle fill.
// Define PHY_TX_SCHED_STATS_EN to add per-lane grant and idle counters.
module phy_tx_scheduler
    import phy_tx_pkg::*;
#(
    parameter int SYNC_CYCLES = 4
) (
    input logic               clk_4f,
    input logic               reset,
    phy_tx_scheduler_if.slave bus
);

    logic [1:0] state_q, state_d;
    lane_t      ptr_q, ptr_d;
    logic [7:0] sync_cnt_q, sync_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    lane_t      lane_id_q, lane_id_d;
    logic       active_q, active_d;

    logic [3:0] req;
    logic [3:0] grant;
    lane_t      gidx;
    logic       arb_en;
    logic [7:0] lane_data;

    assign req    = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
    assign arb_en = bus.enable && bus.tx_ready && (state_q == ST_RUN);

    rr_arbiter4 u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign bus.pop0 = grant[0];
    assign bus.pop1 = grant[1];
    assign bus.pop2 = grant[2];
    assign bus.pop3 = grant[3];

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.lane_id   = lane_id_q;
    assign bus.active    = active_q;

    // Select the byte of the granted lane.
    always_comb begin
        lane_data = bus.data_in0;
        case (gidx)
            2'd1:    lane_data = bus.data_in1;
            2'd2:    lane_data = bus.data_in2;
            2'd3:    lane_data = bus.data_in3;
            default: lane_data = bus.data_in0;
        endcase
    end

    // Link FSM and next value of the serializer output registers.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sync_cnt_d  = sync_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        lane_id_d   = lane_id_q;
        active_d    = active_q;
        if (!bus.enable) begin
            state_d     = ST_IDLE;
            ptr_d       = '0;
            sync_cnt_d  = '0;
            data_out_d  = COM_SYM;
            valid_out_d = 1'b0;
            lane_id_d   = '0;
            active_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SYNC;
                    sync_cnt_d  = '0;
                    data_out_d  = COM_SYM;
                    valid_out_d = 1'b0;
                    lane_id_d   = '0;
                end
                ST_SYNC: begin
                    if (bus.tx_ready) begin
                        data_out_d  = COM_SYM;
                        valid_out_d = 1'b0;
                        lane_id_d   = '0;
                        if (sync_cnt_q == 8'(SYNC_CYCLES - 1)) begin
                            state_d    = ST_RUN;
                            sync_cnt_d = '0;
                            active_d   = 1'b1;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.tx_ready) begin
                        if (|grant) begin
                            data_out_d  = lane_data;
                            valid_out_d = 1'b1;
                            lane_id_d   = gidx;
                            ptr_d       = gidx + lane_t'(1);
                        end else begin
                            data_out_d  = COM_SYM;
                            valid_out_d = 1'b0;
                            lane_id_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sync_cnt_q  <= '0;
            data_out_q  <= COM_SYM;
            valid_out_q <= 1'b0;
            lane_id_q   <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sync_cnt_q  <= sync_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            lane_id_q   <= lane_id_d;
            active_q    <= active_d;
        end
    end

`ifdef PHY_TX_SCHED_STATS_EN
    logic [15:0] grant_cnt_q [4];
    logic [15:0] grant_cnt_d [4];
    logic [15:0] idle_cnt_q, idle_cnt_d;

    assign bus.grant_cnt0 = grant_cnt_q[0];
    assign bus.grant_cnt1 = grant_cnt_q[1];
    assign bus.grant_cnt2 = grant_cnt_q[2];
    assign bus.grant_cnt3 = grant_cnt_q[3];
    assign bus.idle_cnt   = idle_cnt_q;

    // Count pops per lane and COM fills in RUN; disable clears all.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (!bus.enable) begin
                grant_cnt_d[i] = '0;
            end else if (grant[i]) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
        end
        idle_cnt_d = idle_cnt_q;
        if (!bus.enable) begin
            idle_cnt_d = '0;
        end else if (arb_en && !(|grant)) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                grant_cnt_q[i] <= '0;
            end
            idle_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: sync sequence, vector table, disable/reset.
// Builds against the default configuration (PHY_TX_SCHED_STATS_EN off).
module tb_phy_tx_scheduler;

    localparam logic [31:0] DIN = 32'h13121110;

    typedef struct {
        logic [3:0]  valid;
        logic        txr;
        logic [31:0] din;
        logic [3:0]  pop;
        logic [7:0]  dout;
        logic        vout;
        logic [1:0]  lane;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [9:0] sb [$];
    vec_t tbl [21];

    phy_tx_scheduler_if bus_if ();

    phy_tx_scheduler #(.SYNC_CYCLES(4)) dut (
        .clk_4f (clk),
        .reset  (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pops();
        return {bus_if.pop3, bus_if.pop2, bus_if.pop1, bus_if.pop0};
    endfunction

    function automatic logic [1:0] oh_idx(logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic drive(logic [3:0] v, logic txr, logic [31:0] din);
        bus_if.valid0   = v[0];
        bus_if.valid1   = v[1];
        bus_if.valid2   = v[2];
        bus_if.valid3   = v[3];
        bus_if.tx_ready = txr;
        bus_if.data_in0 = din[7:0];
        bus_if.data_in1 = din[15:8];
        bus_if.data_in2 = din[23:16];
        bus_if.data_in3 = din[31:24];
    endtask

    // Push the byte a grant should deliver; compare it one edge later.
    task automatic expect_pop(logic [3:0] p, logic [31:0] din);
        logic [1:0] g;
        g = oh_idx(p);
        sb.push_back({g, din[g*8 +: 8]});
    endtask

    task automatic sb_compare(string name);
        logic [9:0] e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=%0h", name,
                     bus_if.data_out);
        end else begin
            e = sb.pop_front();
            check({name, "_data"}, 32'(bus_if.data_out), 32'(e[7:0]));
            check({name, "_lane"}, 32'(bus_if.lane_id), 32'(e[9:8]));
        end
    endtask

    task automatic do_sync(string tag);
        bus_if.enable = 1'b1;
        drive(4'hF, 1'b1, DIN);
        @(negedge clk);
        check({tag, "_idle_exit_active"}, 32'(bus_if.active), 0);
        for (int j = 0; j < 4; j++) begin
            check({tag, "_sync_pops"}, 32'(pops()), 0);
            @(negedge clk);
            check({tag, "_sync_data"}, 32'(bus_if.data_out), 32'hBC);
            check({tag, "_sync_vout"}, 32'(bus_if.valid_out), 0);
            check({tag, "_sync_active"}, 32'(bus_if.active),
                  32'(j == 3));
        end
        drive(4'h0, 1'b1, DIN);
    endtask

    initial begin
        tbl[0]  = '{4'b0010, 1'b1, 32'h13123A10, 4'b0010, 8'h3A, 1'b1, 2'd1};
        tbl[1]  = '{4'b0000, 1'b1, DIN, 4'b0000, 8'hBC, 1'b0, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, DIN, 4'b0100, 8'h12, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, DIN, 4'b1000, 8'h13, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, DIN, 4'b0001, 8'h10, 1'b1, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, DIN, 4'b0010, 8'h11, 1'b1, 2'd1};
        tbl[6]  = '{4'b1111, 1'b0, DIN, 4'b0000, 8'h11, 1'b1, 2'd1};
        tbl[7]  = '{4'b0100, 1'b0, DIN, 4'b0000, 8'h11, 1'b1, 2'd1};
        tbl[8]  = '{4'b0100, 1'b0, DIN, 4'b0000, 8'h11, 1'b1, 2'd1};
        tbl[9]  = '{4'b0100, 1'b1, DIN, 4'b0100, 8'h12, 1'b1, 2'd2};
        tbl[10] = '{4'b1111, 1'b1, DIN, 4'b1000, 8'h13, 1'b1, 2'd3};
        tbl[11] = '{4'b1111, 1'b1, DIN, 4'b0001, 8'h10, 1'b1, 2'd0};
        tbl[12] = '{4'b1111, 1'b1, DIN, 4'b0010, 8'h11, 1'b1, 2'd1};
        tbl[13] = '{4'b1111, 1'b1, DIN, 4'b0100, 8'h12, 1'b1, 2'd2};
        tbl[14] = '{4'b1111, 1'b1, DIN, 4'b1000, 8'h13, 1'b1, 2'd3};
        tbl[15] = '{4'b1111, 1'b1, DIN, 4'b0001, 8'h10, 1'b1, 2'd0};
        tbl[16] = '{4'b0000, 1'b1, DIN, 4'b0000, 8'hBC, 1'b0, 2'd0};
        tbl[17] = '{4'b1001, 1'b1, DIN, 4'b1000, 8'h13, 1'b1, 2'd3};
        tbl[18] = '{4'b1001, 1'b1, DIN, 4'b0001, 8'h10, 1'b1, 2'd0};
        tbl[19] = '{4'b0001, 1'b1, DIN, 4'b0001, 8'h10, 1'b1, 2'd0};
        tbl[20] = '{4'b0010, 1'b1, DIN, 4'b0010, 8'h11, 1'b1, 2'd1};

        rst_n = 1'b0;
        bus_if.enable = 1'b0;
        drive(4'hF, 1'b1, DIN);
        #12;
        check("rst_data", 32'(bus_if.data_out), 32'hBC);
        check("rst_vout", 32'(bus_if.valid_out), 0);
        check("rst_lane", 32'(bus_if.lane_id), 0);
        check("rst_active", 32'(bus_if.active), 0);
        check("rst_pops", 32'(pops()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_pops", 32'(pops()), 0);
        check("idle_data", 32'(bus_if.data_out), 32'hBC);

        do_sync("s1");

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].valid, tbl[i].txr, tbl[i].din);
            #1;
            check($sformatf("v%0d_pop", i), 32'(pops()), 32'(tbl[i].pop));
            if (tbl[i].pop != 4'b0) expect_pop(tbl[i].pop, tbl[i].din);
            @(negedge clk);
            check($sformatf("v%0d_data", i), 32'(bus_if.data_out),
                  32'(tbl[i].dout));
            check($sformatf("v%0d_vout", i), 32'(bus_if.valid_out),
                  32'(tbl[i].vout));
            check($sformatf("v%0d_lane", i), 32'(bus_if.lane_id),
                  32'(tbl[i].lane));
            check($sformatf("v%0d_active", i), 32'(bus_if.active), 1);
            if (tbl[i].pop != 4'b0) sb_compare($sformatf("v%0d_sb", i));
        end

        bus_if.enable = 1'b0;
        drive(4'b0001, 1'b1, DIN);
        #1;
        check("dis_pop0", 32'(pops()), 0);
        @(negedge clk);
        check("dis_active", 32'(bus_if.active), 0);
        check("dis_vout", 32'(bus_if.valid_out), 0);
        check("dis_data", 32'(bus_if.data_out), 32'hBC);
        @(negedge clk);
        check("dis_hold_pops", 32'(pops()), 0);

        do_sync("s2");
        drive(4'hF, 1'b1, DIN);
        #1;
        check("resync_ptr0_pop", 32'(pops()), 32'b0001);
        expect_pop(4'b0001, DIN);
        @(negedge clk);
        sb_compare("resync_sb");

        drive(4'b0010, 1'b1, DIN);
        #1;
        check("pre_rst_pop", 32'(pops()), 32'b0010);
        expect_pop(4'b0010, DIN);
        @(negedge clk);
        sb_compare("pre_rst_sb");
        check("pre_rst_vout", 32'(bus_if.valid_out), 1);
        drive(4'b0100, 1'b1, DIN);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vout", 32'(bus_if.valid_out), 0);
        check("arst_data", 32'(bus_if.data_out), 32'hBC);
        check("arst_lane", 32'(bus_if.lane_id), 0);
        check("arst_active", 32'(bus_if.active), 0);
        check("arst_pops", 32'(pops()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
